cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Round-robin arbiter that shares the single Common Data Bus (CDB) among NREQ functional-unit result ports.
- Drives the registered {valid, tag} token consumed by the register status table's tag comparators, plus result data for the reservation stations and reorder buffer.
- Sits between the functional-unit writeback ports and the CDB consumers.
- Provides stall (cdb_hold) and flush control.

Parameters:
- NREQ, 4, number of requesting functional units; power of two, 2..8.
- TAG_W, 5, reorder-buffer tag width.
- DATA_W, 32, result data width.
- CNT_W, 16, broadcast counter width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: unit i holds a result to broadcast.
- req_tag  in  NREQ*TAG_W  unit i tag in slice [i*TAG_W +: TAG_W].
- req_data  in  NREQ*DATA_W  unit i data in slice [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  one-hot grant; combinational, same cycle as request.
- cdb_hold  in  1  consumer stall; freezes the CDB and blocks grants.
- flush  in  1  mispredict/exception flush.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  TAG_W  registered broadcast tag.
- cdb_data  out  DATA_W  registered broadcast data.
- cdb_src  out  log2(NREQ)  index of the unit that owns the current broadcast.
- bcast_cnt  out  CNT_W  count of completed broadcasts; saturating.

Behaviour:
- Handshake:
  - Unit i keeps req_valid[i], tag and data stable until it sees req_ready[i]=1 on a rising edge.
  - The transfer occurs on that edge.
  - req_valid may drop only after a transfer, or because of a flush.
- Grant enable: en = !flush & !cdb_hold. While en=0, req_ready is all zero.
- Selection:
  - Search indices rr_ptr, rr_ptr+1, ... modulo NREQ.
  - The first i with req_valid[i]=1 is granted.
  - At most one req_ready bit is high.
- Pointer:
  - On a grant of i, rr_ptr <= (i+1) mod NREQ.
  - Otherwise rr_ptr holds, including during flush and hold.
- Output register, next-state priority (highest first):
  1. reset: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0, bcast_cnt=0.
  2. flush: cdb_valid<=0. Tag, data and src hold. No grant is made.
  3. cdb_hold: all outputs hold their values. A held valid broadcast stays asserted.
  4. grant of i: cdb_valid<=1, cdb_tag<=tag_i, cdb_data<=data_i, cdb_src<=i.
  5. no request: cdb_valid<=0. Tag, data and src hold.
- Latency:
  - Grant to cdb_valid is 1 cycle.
  - Back-to-back grants give one broadcast per cycle; full throughput.
- bcast_cnt:
  - Increments on each cycle where cdb_valid=1 and cdb_hold=0 and flush=0 (the broadcast is consumed).
  - Saturates at all-ones.
  - Held cycles do not increment it.
- Flush:
  - A flush in the same cycle as a pending broadcast kills that broadcast: cdb_valid drops next cycle and the count does not increment.
  - Requesters clear their own req_valid on flush.
- Reset mid-operation: reset overrides flush and hold. Pending requests are not granted in the reset cycle.
- Single requester: the same unit is granted every cycle while its req_valid stays high.
- Wrap-around: with rr_ptr=NREQ-1 and only unit 0 requesting, unit 0 is granted.
- No combinational path from cdb_* outputs to req_ready other than through cdb_hold and flush.

Test Plan:
- Reset then idle: after reset, with req_valid=0000 for 5 cycles → cdb_valid=0, req_ready=0000, bcast_cnt=0.
- All-requesters fairness: req_valid=1111, tags 3/7/11/20, held until granted and then re-asserted.
  - Expected grant order: 0,1,2,3,0,...
  - cdb_tag sequence one cycle later: 3,7,11,20,3.
  - bcast_cnt=5 after 5 broadcasts.
- Wrap-around: grant unit 3 (rr_ptr becomes 0), then assert only unit 1, tag 9 → req_ready=0010, next cycle cdb_tag=9, cdb_src=1.
- Hold: while cdb_valid=1 with tag 7, assert cdb_hold for 3 cycles with unit 2 requesting.
  - Required: cdb_tag stays 7, cdb_valid stays 1, req_ready=0000, bcast_cnt frozen.
  - Unit 2 is granted in the first cycle after hold drops.
- Flush: grant unit 0 (tag 5) and assert flush in the following cycle → cdb_valid=0 next cycle, no grant during the flush cycle, rr_ptr unchanged, bcast_cnt not incremented.
- Saturation and reset: drive bcast_cnt to 16'hFFFF, broadcast again → stays FFFF. Assert reset with requests pending → all outputs return to 0 and req_ready=0000.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter that shares the single Common Data Bus among NREQ
// functional-unit writeback ports. The winning {tag, data} is captured into a
// registered broadcast. Reservation stations, the ROB and the register status
// table's tag comparators consume that broadcast one cycle after the grant.
//
// Parameters
//   NREQ    number of requesting units (power of two, 2..8)
//   TAG_W   reorder-buffer tag width
//   DATA_W  result data width
//   CNT_W   width of the saturating broadcast counter
//
// Ports
//   clock      system clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   req_valid  per-unit request, held until granted
//   req_tag    unit i tag in [i*TAG_W +: TAG_W]
//   req_data   unit i data in [i*DATA_W +: DATA_W]
//   req_ready  one-hot grant, combinational in the request cycle
//   cdb_hold   consumer stall: freezes the broadcast and blocks grants
//   flush      kills the pending broadcast and blocks grants
//   cdb_valid  registered broadcast valid
//   cdb_tag    registered broadcast tag
//   cdb_data   registered broadcast data
//   cdb_src    index of the unit that owns the current broadcast
//   bcast_cnt  number of consumed broadcasts, saturating at all-ones
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     cdb_hold,
  input  logic                     flush,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [SRC_W-1:0]         cdb_src,
  output logic [CNT_W-1:0]         bcast_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic                 cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]     cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0]    cdb_data_q,  cdb_data_d;
  logic [SRC_W-1:0]     cdb_src_q,   cdb_src_d;
  logic [CNT_W-1:0]     bcast_cnt_q, bcast_cnt_d;
  logic [SRC_W-1:0]     rr_ptr_q,    rr_ptr_d;

  logic                 en;
  logic                 gnt_vld;
  logic [SRC_W-1:0]     gnt_idx;
  logic [SRC_W-1:0]     scan_idx;
  logic                 consumed;

  logic [TAG_W-1:0]     tag_arr  [NREQ];
  logic [DATA_W-1:0]    data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign tag_arr[gi]  = req_tag[gi*TAG_W +: TAG_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Reset is folded into the enable so nothing is granted in a reset cycle.
  // The grant depends only on requests, pointer and the two stall inputs,
  // never on the broadcast registers.
  assign en = !reset && !flush && !cdb_hold;

  // Scan from rr_ptr upwards; NREQ is a power of two so the SRC_W-bit add
  // wraps modulo NREQ for free.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    req_ready = '0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = rr_ptr_q + SRC_W'(k);
        if (!gnt_vld && req_valid[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // A broadcast is consumed only when it is neither stalled nor killed.
  assign consumed = cdb_valid_q && !cdb_hold && !flush;

  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    rr_ptr_d    = gnt_vld ? gnt_idx + SRC_W'(1) : rr_ptr_q;
    bcast_cnt_d = consumed ? sat_inc(bcast_cnt_q) : bcast_cnt_q;

    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (cdb_hold) begin
      cdb_valid_d = cdb_valid_q;
    end else if (gnt_vld) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = tag_arr[gnt_idx];
      cdb_data_d  = data_arr[gnt_idx];
      cdb_src_d   = gnt_idx;
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  // Broadcast register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
      bcast_cnt_q <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      rr_ptr_q    <= rr_ptr_d;
      bcast_cnt_q <= bcast_cnt_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign bcast_cnt = bcast_cnt_q;

endmodule
